// File: rtl/mtmp_sched.sv
// Round-robin scheduler sharing one fixed-latency mtmp datapath among NREQ requesters.
// Results return in acceptance order, tagged with the originating requester id.
module mtmp_sched #(
   parameter int NREQ   = 4,
   parameter int DW_IN  = 10,
   parameter int DW_DEC = 8,
   parameter int LAT    = 6,
   parameter int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_vld,
   output logic [NREQ-1:0]        req_rdy,
   input  logic [NREQ*DW_IN-1:0]  req_ii_jj,
   input  logic [NREQ*DW_IN-1:0]  req_i_j,
   input  logic                   halt,
   output logic [DW_IN-1:0]       dp_imoy_ii_jj,
   output logic [DW_IN-1:0]       dp_imoy_i_j,
   input  logic [DW_DEC:0]        dp_mtmp,
   output logic                   res_vld,
   output logic [IDW-1:0]         res_id,
   output logic [DW_DEC:0]        res_mtmp,
   output logic                   busy
);

   logic [IDW-1:0]   last_grant;
   logic [IDW-1:0]   grant_id;
   logic [IDW-1:0]   cand_id;
   logic [NREQ-1:0]  eligible;
   logic             found;
   logic             transfer;
   logic [DW_IN-1:0] sel_ii_jj;
   logic [DW_IN-1:0] sel_i_j;
   logic [LAT:0]     tag_vld;
   logic [IDW-1:0]   tag_id [LAT+1];
   int               cand;

   // Search starts one past the last grant; reset low also blocks grants.
   always_comb begin
      eligible = req_vld & ~{NREQ{halt}} & {NREQ{rst_n}};
      req_rdy  = '0;
      grant_id = '0;
      found    = 1'b0;
      cand     = 0;
      cand_id  = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = int'(last_grant) + i;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         cand_id = IDW'(cand);
         if (!found && eligible[cand_id]) begin
            found            = 1'b1;
            grant_id         = cand_id;
            req_rdy[cand_id] = 1'b1;
         end
      end
   end

   assign transfer = |req_rdy;

   always_comb begin
      sel_ii_jj = '0;
      sel_i_j   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (req_rdy[k]) begin
            sel_ii_jj = req_ii_jj[k*DW_IN +: DW_IN];
            sel_i_j   = req_i_j[k*DW_IN +: DW_IN];
         end
      end
   end

   // Operands and the tag enter together so the tag's last stage lines up with dp_mtmp.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant    <= IDW'(NREQ - 1);
         dp_imoy_ii_jj <= '0;
         dp_imoy_i_j   <= '0;
         tag_vld       <= '0;
         for (int k = 0; k <= LAT; k++) begin
            tag_id[k] <= '0;
         end
         res_vld  <= 1'b0;
         res_id   <= '0;
         res_mtmp <= '0;
      end else begin
         dp_imoy_ii_jj <= sel_ii_jj;
         dp_imoy_i_j   <= sel_i_j;
         tag_vld       <= {tag_vld[LAT-1:0], transfer};
         tag_id[0]     <= grant_id;
         for (int k = 1; k <= LAT; k++) begin
            tag_id[k] <= tag_id[k-1];
         end
         res_vld  <= tag_vld[LAT];
         res_id   <= tag_id[LAT];
         res_mtmp <= tag_vld[LAT] ? dp_mtmp : '0;
         if (transfer) begin
            last_grant <= grant_id;
         end
      end
   end

   // A request still counts as in flight during the cycle its result is presented.
   assign busy = (|tag_vld) | res_vld;

endmodule
